// File: rtl/proj_pkg.sv
// Shared instruction types and the opcode extractor used by the queue and the control FSM decoder.
package proj_pkg;
   localparam int INSTR_W = 16;
   localparam int OP_W    = 4;

   typedef logic [INSTR_W-1:0] instr_t;
   typedef logic [OP_W-1:0]    opcode_t;

   function automatic opcode_t get_opcode(instr_t instr);
      return instr[INSTR_W-1 -: OP_W];
   endfunction
endpackage

// File: rtl/instr_queue_ptr.sv
// Circular index 0..DEPTH-1; wraps by explicit compare so DEPTH need not be a power of two.
// Single-cycle update; clr wins over inc.
module instr_queue_ptr #(
   parameter int DEPTH = 4,
   parameter int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr,
   input  logic             inc,
   output logic [PTR_W-1:0] ptr
);
   logic [PTR_W-1:0] ptr_q, ptr_d;

   always_comb begin
      ptr_d = ptr_q;
      if (clr) begin
         ptr_d = '0;
      end else if (inc) begin
         ptr_d = (ptr_q == PTR_W'(DEPTH - 1)) ? '0 : ptr_q + PTR_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) ptr_q <= '0;
      else        ptr_q <= ptr_d;
   end

   assign ptr = ptr_q;
endmodule

// File: rtl/instr_queue.sv
// In-order instruction buffer between fetch and the control FSM; head visible combinationally, 1-cycle load-to-out.
// A load into a full queue without a same-cycle take is dropped and sets the sticky ovf flag.
module instr_queue #(
   parameter int DATA_W = proj_pkg::INSTR_W,
   parameter int DEPTH  = 4,
   parameter int OP_W   = proj_pkg::OP_W
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [DATA_W-1:0]          data,
   input  logic                       load,
   input  logic                       take,
   input  logic                       flush,
   output logic [DATA_W-1:0]          out,
   output logic [OP_W-1:0]            opcode,
   output logic                       valid,
   output logic                       full,
   output logic [$clog2(DEPTH+1)-1:0] count,
   output logic                       ovf
);
   import proj_pkg::*;

   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   if (OP_W > DATA_W) begin : g_op_chk
      $error("instr_queue: OP_W must not exceed DATA_W");
   end
   if (DEPTH < 1 || DEPTH > 16) begin : g_depth_chk
      $error("instr_queue: DEPTH must be within 1..16");
   end

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [DATA_W-1:0] mem_d [DEPTH];
   logic [CNT_W-1:0]  count_q, count_d;
   logic              ovf_q, ovf_d;
   logic [PTR_W-1:0]  wr_ptr, rd_ptr;
   logic              push, pop;

   assign valid = (count_q != '0);
   assign full  = (count_q == CNT_W'(DEPTH));
   assign count = count_q;
   assign ovf   = ovf_q;

   // A full queue still accepts a load when the head leaves on the same edge.
   assign pop  = !flush && take && valid;
   assign push = !flush && load && (!full || pop);

   always_comb begin
      count_d = count_q;
      ovf_d   = ovf_q;
      if (flush) begin
         count_d = '0;
         ovf_d   = 1'b0;
      end else begin
         count_d = count_q + CNT_W'(push) - CNT_W'(pop);
         if (load && full && !take) ovf_d = 1'b1;
      end
   end

   always_comb begin
      mem_d = mem_q;
      if (push) mem_d[wr_ptr] = data;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= '0;
         ovf_q   <= 1'b0;
      end else begin
         count_q <= count_d;
         ovf_q   <= ovf_d;
      end
   end

   // Storage contents are don't-care after reset, so no reset here.
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

   instr_queue_ptr #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_wr_ptr (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (flush),
      .inc   (push),
      .ptr   (wr_ptr)
   );

   instr_queue_ptr #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_rd_ptr (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (flush),
      .inc   (pop),
      .ptr   (rd_ptr)
   );

   assign out = valid ? mem_q[rd_ptr] : '0;

   if (DATA_W == INSTR_W && OP_W == proj_pkg::OP_W) begin : g_op_pkg
      assign opcode = get_opcode(out);
   end else begin : g_op_slice
      assign opcode = out[DATA_W-1 -: OP_W];
   end
endmodule

// File: tb/tb_instr_queue.sv
// Directed checks of instr_queue at DEPTH=4 (table of per-edge vectors) and DEPTH=1 (hand sequence).
module tb_instr_queue;
   logic        clk = 1'b0;
   logic        rst_n;
   logic [15:0] data, data1;
   logic        load, take, flush, load1, take1, flush1;
   logic [15:0] out, out1;
   logic [3:0]  opcode, opcode1;
   logic        valid, full, ovf, valid1, full1, ovf1;
   logic [2:0]  count;
   logic [0:0]  count1;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   instr_queue #(.DATA_W(16), .DEPTH(4), .OP_W(4)) u_dut (
      .clk(clk), .rst_n(rst_n), .data(data), .load(load), .take(take), .flush(flush),
      .out(out), .opcode(opcode), .valid(valid), .full(full), .count(count), .ovf(ovf)
   );

   instr_queue #(.DATA_W(16), .DEPTH(1), .OP_W(4)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .data(data1), .load(load1), .take(take1), .flush(flush1),
      .out(out1), .opcode(opcode1), .valid(valid1), .full(full1), .count(count1), .ovf(ovf1)
   );

   typedef struct {
      logic        ld;
      logic        tk;
      logic        fl;
      logic [15:0] din;
      logic [15:0] e_out;
      logic [2:0]  e_cnt;
      logic        e_full;
      logic        e_ovf;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(logic ld, logic tk, logic fl, logic [15:0] din,
                               logic [15:0] e_out, logic [2:0] e_cnt, logic e_full, logic e_ovf);
      vec_t v;
      v.ld = ld; v.tk = tk; v.fl = fl; v.din = din;
      v.e_out = e_out; v.e_cnt = e_cnt; v.e_full = e_full; v.e_ovf = e_ovf;
      return v;
   endfunction

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [15:0] eo;
      rst_n = 1'b0;
      data = '0; load = 0; take = 0; flush = 0;
      data1 = '0; load1 = 0; take1 = 0; flush1 = 0;
      #2;
      chk("rst_out", out, 0);
      chk("rst_valid", valid, 0);
      chk("rst_full", full, 0);
      chk("rst_count", count, 0);
      chk("rst_ovf", ovf, 0);
      chk("rst_opcode", opcode, 0);
      step();
      rst_n = 1'b1;

      // Reset mid-stream, asserted between edges
      load = 1; data = 16'h1234; step();
      data = 16'h2345; step();
      load = 0;
      chk("mid_count_pre", count, 2);
      chk("mid_out_pre", out, 16'h1234);
      #2 rst_n = 1'b0;
      #1;
      chk("mid_rst_out", out, 0);
      chk("mid_rst_valid", valid, 0);
      chk("mid_rst_count", count, 0);
      chk("mid_rst_ovf", ovf, 0);
      #1 rst_n = 1'b1;
      step();

      //            ld tk fl  data      out       cnt full ovf
      vecs.push_back(mk(1, 0, 0, 16'hA001, 16'hA001, 1, 0, 0));
      vecs.push_back(mk(1, 0, 0, 16'hA002, 16'hA001, 2, 0, 0));
      vecs.push_back(mk(1, 0, 0, 16'hA003, 16'hA001, 3, 0, 0));
      vecs.push_back(mk(1, 0, 0, 16'hA004, 16'hA001, 4, 1, 0));
      vecs.push_back(mk(1, 0, 0, 16'hBEEF, 16'hA001, 4, 1, 1));
      vecs.push_back(mk(0, 1, 0, 16'h0000, 16'hA002, 3, 0, 1));
      vecs.push_back(mk(0, 1, 0, 16'h0000, 16'hA003, 2, 0, 1));
      vecs.push_back(mk(0, 1, 0, 16'h0000, 16'hA004, 1, 0, 1));
      vecs.push_back(mk(0, 1, 0, 16'h0000, 16'h0000, 0, 0, 1));
      vecs.push_back(mk(0, 1, 0, 16'h0000, 16'h0000, 0, 0, 1));
      vecs.push_back(mk(0, 0, 1, 16'h0000, 16'h0000, 0, 0, 0));
      vecs.push_back(mk(1, 0, 0, 16'hB001, 16'hB001, 1, 0, 0));
      vecs.push_back(mk(1, 0, 0, 16'hB002, 16'hB001, 2, 0, 0));
      vecs.push_back(mk(1, 0, 0, 16'hB003, 16'hB001, 3, 0, 0));
      vecs.push_back(mk(1, 0, 0, 16'hB004, 16'hB001, 4, 1, 0));
      vecs.push_back(mk(1, 1, 0, 16'hC0DE, 16'hB002, 4, 1, 0));
      vecs.push_back(mk(0, 1, 0, 16'h0000, 16'hB003, 3, 0, 0));
      vecs.push_back(mk(0, 1, 0, 16'h0000, 16'hB004, 2, 0, 0));
      vecs.push_back(mk(0, 1, 0, 16'h0000, 16'hC0DE, 1, 0, 0));
      vecs.push_back(mk(0, 1, 0, 16'h0000, 16'h0000, 0, 0, 0));
      vecs.push_back(mk(1, 1, 0, 16'h0F0F, 16'h0F0F, 1, 0, 0));
      vecs.push_back(mk(0, 1, 0, 16'h0000, 16'h0000, 0, 0, 0));
      for (int i = 1; i <= 6; i++)
         vecs.push_back(mk(1, 1, 0, 16'hD000 + 16'(i), 16'hD000 + 16'(i), 1, 0, 0));
      vecs.push_back(mk(1, 1, 1, 16'hEEEE, 16'h0000, 0, 0, 0));
      vecs.push_back(mk(1, 0, 0, 16'h5555, 16'h5555, 1, 0, 0));
      vecs.push_back(mk(0, 1, 0, 16'h0000, 16'h0000, 0, 0, 0));

      for (int i = 0; i < vecs.size(); i++) begin
         load = vecs[i].ld; take = vecs[i].tk; flush = vecs[i].fl; data = vecs[i].din;
         step();
         eo = vecs[i].e_out;
         chk($sformatf("v%0d_out", i), out, eo);
         chk($sformatf("v%0d_opcode", i), opcode, eo[15:12]);
         chk($sformatf("v%0d_count", i), count, vecs[i].e_cnt);
         chk($sformatf("v%0d_valid", i), valid, vecs[i].e_cnt != 0);
         chk($sformatf("v%0d_full", i), full, vecs[i].e_full);
         chk($sformatf("v%0d_ovf", i), ovf, vecs[i].e_ovf);
      end
      load = 0; take = 0; flush = 0;

      // DEPTH=1 build
      chk("d1_idle_valid", valid1, 0);
      load1 = 1; data1 = 16'h0007; step();
      chk("d1_out", out1, 16'h0007);
      chk("d1_full", full1, 1);
      chk("d1_count", count1, 1);
      chk("d1_ovf_clear", ovf1, 0);
      data1 = 16'h0009; step();
      chk("d1_hold_out", out1, 16'h0007);
      chk("d1_ovf", ovf1, 1);
      data1 = 16'h000A; take1 = 1; step();
      chk("d1_reload_out", out1, 16'h000A);
      chk("d1_reload_count", count1, 1);
      chk("d1_ovf_sticky", ovf1, 1);
      load1 = 0; step();
      chk("d1_drain_valid", valid1, 0);
      chk("d1_drain_out", out1, 0);
      take1 = 0; flush1 = 1; step();
      chk("d1_flush_ovf", ovf1, 0);
      flush1 = 0;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
